note_lane: RTL

NOTE_LANE -- requirements
Module: note_lane

---
 rtl/note_lane.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/note_lane.sv
// One falling note lane: a block drops down the lane on a move tick, can be
// hit inside the zone for a point, and is lost once it falls past the bottom.
//
// state | meaning
// IDLE  | waiting for enable, block parked at the spawn line
// FALL  | block moving down STEP lines per move tick
// HIT   | block frozen and painted green for HIT_TICKS move ticks
// GONE  | block lost, lane dead until reset
module note_lane #(
    parameter int LANE_X      = 144,
    parameter int LANE_W      = 160,
    parameter int BLOCK_H     = 40,
    parameter int TOP_Y       = 35,
    parameter int BOTTOM_Y    = 515,
    parameter int ZONE_TOP    = 400,
    parameter int ZONE_BOT    = 455,
    parameter int BASE_PERIOD = 500000,
    parameter int MIN_PERIOD  = 50000,
    parameter int STEP        = 2,
    parameter int HIT_TICKS   = 8
) (
    input  logic        clk,
    input  logic        resetbtn,
    input  logic        enable,
    input  logic        hitbtn,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic [49:0] speedshift,
    output logic [1:0]  flag,
    output logic        pointflag,
    output logic        blockgoneflag
);

    localparam int HW = (HIT_TICKS > 1) ? $clog2(HIT_TICKS + 1) : 1;
    localparam logic [49:0] BASE_P = 50'(BASE_PERIOD);
    localparam logic [49:0] MIN_P  = 50'(MIN_PERIOD);
    localparam logic [49:0] SPAN_P = BASE_P - MIN_P;

    typedef enum logic [1:0] {IDLE, FALL, HIT, GONE} state_t;

    state_t        state_q, state_n;
    logic [9:0]    y_q, y_n;
    logic [49:0]   cnt_q, cnt_n;
    logic [49:0]   per_q, per_n;
    logic [HW-1:0] hold_q, hold_n;
    logic [1:0]    flag_n;
    logic          point_n, gone_n;

    logic [49:0]   per_calc;
    logic          tick;
    logic [10:0]   y_end;
    logic          hit;
    logic          in_lane;
    logic          in_rows;

    assign per_calc = (speedshift < SPAN_P) ? (BASE_P - speedshift) : MIN_P;
    assign tick     = (cnt_q == per_q - 50'd1);
    // 11-bit bottom edge so a block near line 1023 cannot wrap
    assign y_end    = {1'b0, y_q} + 11'(BLOCK_H);
    assign hit      = (state_q == FALL) && enable && hitbtn &&
                      (y_end > 11'(ZONE_TOP)) && (y_q <= 10'(ZONE_BOT));
    assign in_lane  = ({1'b0, hCount} >= 11'(LANE_X)) &&
                      ({1'b0, hCount} < 11'(LANE_X + LANE_W));
    assign in_rows  = (vCount >= y_q) && ({1'b0, vCount} < y_end);

    always_ff @(posedge clk or posedge resetbtn) begin
        if (resetbtn) begin
            state_q       <= IDLE;
            y_q           <= 10'(TOP_Y);
            cnt_q         <= '0;
            per_q         <= MIN_P;
            hold_q        <= '0;
            flag          <= 2'b00;
            pointflag     <= 1'b0;
            blockgoneflag <= 1'b0;
        end else begin
            state_q       <= state_n;
            y_q           <= y_n;
            cnt_q         <= cnt_n;
            per_q         <= per_n;
            hold_q        <= hold_n;
            flag          <= flag_n;
            pointflag     <= point_n;
            blockgoneflag <= gone_n;
        end
    end

    always_comb begin
        state_n = state_q;
        y_n     = y_q;
        cnt_n   = cnt_q;
        per_n   = per_q;
        hold_n  = hold_q;
        point_n = 1'b0;
        gone_n  = blockgoneflag;
        flag_n  = 2'b00;

        if (in_lane && in_rows) begin
            if (state_q == FALL)
                flag_n = 2'b01;
            else if (state_q == HIT)
                flag_n = 2'b10;
        end

        if (enable) begin
            // the period is only picked up when the count restarts
            if (state_q == FALL || state_q == HIT) begin
                if (tick) begin
                    cnt_n = '0;
                    per_n = per_calc;
                end else begin
                    cnt_n = cnt_q + 50'd1;
                end
            end

            case (state_q)
                IDLE: begin
                    state_n = FALL;
                    y_n     = 10'(TOP_Y);
                    cnt_n   = '0;
                    per_n   = per_calc;
                end
                FALL: begin
                    if (hit) begin
                        state_n = HIT;
                        hold_n  = HW'(HIT_TICKS);
                        point_n = 1'b1;
                    end else if (y_q > 10'(BOTTOM_Y)) begin
                        state_n = GONE;
                        gone_n  = 1'b1;
                    end else if (tick) begin
                        y_n = y_q + 10'(STEP);
                    end
                end
                HIT: begin
                    if (tick) begin
                        if (hold_q <= HW'(1)) begin
                            state_n = FALL;
                            y_n     = 10'(TOP_Y);
                            hold_n  = '0;
                        end else begin
                            hold_n = hold_q - HW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
